// File: rtl/cpu_v1_pkg.sv
// Shared definitions for the cpu_v1 single-cycle core: sizes, opcodes,
// ALU function select and the decode-control record.
package cpu_v1_pkg;

    localparam int DATA_W    = 8;
    localparam int NUM_REGS  = 16;
    localparam int REG_AW    = $clog2(NUM_REGS);
    localparam int NUM_FLAGS = 3;
    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_N    = 2;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_LDI = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR, ALU_PASS
    } alu_func_e;

    typedef struct packed {
        logic      inv_b;
        logic      carry_in;
        alu_func_e func;
    } alu_ctrl_t;

    typedef struct packed {
        logic      write_en;
        logic      ldi_sel;
        logic      flag_en;
        alu_ctrl_t alu;
    } decode_t;

    localparam decode_t DEC_NOP = '{
        write_en: 1'b0, ldi_sel: 1'b0, flag_en: 1'b0,
        alu: '{inv_b: 1'b0, carry_in: 1'b0, func: ALU_PASS}
    };

    // Every ALU opcode writes rd and updates the flags; only the ALU control differs.
    function automatic decode_t alu_dec(alu_func_e func, logic inv_b, logic carry_in);
        decode_t d;
        d              = DEC_NOP;
        d.write_en     = 1'b1;
        d.flag_en      = 1'b1;
        d.alu.func     = func;
        d.alu.inv_b    = inv_b;
        d.alu.carry_in = carry_in;
        return d;
    endfunction

endpackage

// File: rtl/cpu_v1_alu.sv
// Combinational 8-bit ALU; SUB is ADD with inverted b and carry-in set,
// so carry-out means "no borrow".
module cpu_v1_alu
    import cpu_v1_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_ctrl_t         ctrl,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              n
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        result = '0;
        c      = 1'b0;
        b_eff  = ctrl.inv_b ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, ctrl.carry_in};
        case (ctrl.func)
            ALU_ADD:  begin result = sum[DATA_W-1:0]; c = sum[DATA_W]; end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_SHL:  begin result = {a[DATA_W-2:0], 1'b0}; c = a[DATA_W-1]; end
            ALU_SHR:  begin result = {1'b0, a[DATA_W-1:1]}; c = a[0]; end
            ALU_PASS: result = a;
        endcase
    end

    assign z = (result == '0);
    assign n = result[DATA_W-1];

endmodule

// File: rtl/cpu_v1_core.sv
// Single-cycle core: inline decode table, 16x8 register file with hardwired
// x0, ALU and registered Z/C/N flags. One instruction retires per clock.
module cpu_v1_core
    import cpu_v1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       inst,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n
);

    logic [3:0]          op;
    logic [REG_AW-1:0]   rd, rs1, rs2;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_FLAGS-1:0] flags;
    logic [DATA_W-1:0]   rs1_val, rs2_val, alu_result, wdata;
    logic                alu_z, alu_c, alu_n;
    decode_t             dec;

    assign op  = inst[15:12];
    assign rd  = inst[11:8];
    assign rs1 = inst[7:4];
    assign rs2 = inst[3:0];
    assign imm = inst[7:0];

    // x0 is forced to zero on every read port, independent of storage.
    assign rs1_val  = (rs1 == '0)      ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == '0)      ? '0 : regs[rs2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    always_comb begin
        dec = DEC_NOP;
        case (op)
            OP_ADD:  dec = alu_dec(ALU_ADD,  1'b0, 1'b0);
            OP_SUB:  dec = alu_dec(ALU_ADD,  1'b1, 1'b1);
            OP_AND:  dec = alu_dec(ALU_AND,  1'b0, 1'b0);
            OP_OR:   dec = alu_dec(ALU_OR,   1'b0, 1'b0);
            OP_XOR:  dec = alu_dec(ALU_XOR,  1'b0, 1'b0);
            OP_NOT:  dec = alu_dec(ALU_NOT,  1'b0, 1'b0);
            OP_SHL:  dec = alu_dec(ALU_SHL,  1'b0, 1'b0);
            OP_SHR:  dec = alu_dec(ALU_SHR,  1'b0, 1'b0);
            OP_MOV:  dec = alu_dec(ALU_PASS, 1'b0, 1'b0);
            OP_LDI:  begin
                dec.write_en = 1'b1;
                dec.ldi_sel  = 1'b1;
            end
            default: dec = DEC_NOP;
        endcase
    end

    cpu_v1_alu u_alu (
        .a      (rs1_val),
        .b      (rs2_val),
        .ctrl   (dec.alu),
        .result (alu_result),
        .z      (alu_z),
        .c      (alu_c),
        .n      (alu_n)
    );

    assign wdata = dec.ldi_sel ? imm : alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is plain flops, so it may be cleared in reset; an SRAM macro could not be.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flags <= '0;
        end else begin
            // NOTE: non-blocking updates keep same-cycle reads of rd at the pre-edge value.
            if (dec.write_en && rd != '0) regs[rd] <= wdata;
            if (dec.flag_en) begin
                flags[FLAG_Z] <= alu_z;
                flags[FLAG_C] <= alu_c;
                flags[FLAG_N] <= alu_n;
            end
        end
    end

    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_n = flags[FLAG_N];

endmodule

// File: tb/tb_cpu_v1_core.sv
// Self-checking bench for cpu_v1_core: directed vector table, async reset
// sequence and random instructions against an arithmetic reference model.
module tb_cpu_v1_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inst = 16'h9000;
    logic [3:0]  dbg_addr = 4'd0;
    logic [7:0]  dbg_data;
    logic        flag_z, flag_c, flag_n;

    int errors = 0;
    int checks = 0;

    int m_regs [16];
    int m_z, m_c, m_n;

    typedef struct {
        logic [15:0] inst;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [2:0]  znc;
    } vec_t;

    vec_t vecs [$];

    cpu_v1_core dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_rd(input int idx);
        return (idx == 0) ? 0 : m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_z = 0; m_c = 0; m_n = 0;
    endtask

    // Reference semantics computed with plain integer arithmetic.
    task automatic model_exec(input logic [15:0] i);
        int op, rd, a, b, r, c;
        op = int'(i[15:12]);
        rd = int'(i[11:8]);
        a  = m_rd(int'(i[7:4]));
        b  = m_rd(int'(i[3:0]));
        r  = 0;
        c  = 0;
        case (op)
            0: begin r = a + b; c = (r > 255) ? 1 : 0; end
            1: begin r = a - b; c = (a >= b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; c = (a >= 128) ? 1 : 0; end
            7: begin r = a / 2; c = a % 2; end
            8: r = a;
            15: if (rd != 0) m_regs[rd] = int'(i[7:0]);
            default: ;
        endcase
        if (op <= 8) begin
            r = (r + 256) % 256;
            if (rd != 0) m_regs[rd] = r;
            m_z = (r == 0) ? 1 : 0;
            m_c = c;
            m_n = (r >= 128) ? 1 : 0;
        end
    endtask

    task automatic step(input logic [15:0] i);
        inst = i;
        @(posedge clk);
        model_exec(i);
        #1;
    endtask

    task automatic check_flags(input string name);
        check({name, " z"}, int'(flag_z), m_z);
        check({name, " c"}, int'(flag_c), m_c);
        check({name, " n"}, int'(flag_n), m_n);
    endtask

    // Holds a NOP so the sweep may span clock edges without side effects.
    task automatic sweep(input string name);
        inst = 16'h9000;
        for (int r = 0; r < 16; r++) begin
            dbg_addr = 4'(r);
            #1;
            check($sformatf("%s x%0d", name, r), int'(dbg_data), m_rd(r));
        end
        check_flags(name);
    endtask

    initial begin
        vecs.push_back('{16'hF10A, 4'd1, 8'h0A, 3'b000});
        vecs.push_back('{16'hF202, 4'd2, 8'h02, 3'b000});
        vecs.push_back('{16'h0112, 4'd1, 8'h0C, 3'b000});
        vecs.push_back('{16'hF203, 4'd2, 8'h03, 3'b000});
        vecs.push_back('{16'h1112, 4'd1, 8'h09, 3'b010});
        vecs.push_back('{16'hF102, 4'd1, 8'h02, 3'b010});
        vecs.push_back('{16'hF203, 4'd2, 8'h03, 3'b010});
        vecs.push_back('{16'h1312, 4'd3, 8'hFF, 3'b001});
        vecs.push_back('{16'hF1FF, 4'd1, 8'hFF, 3'b001});
        vecs.push_back('{16'hF201, 4'd2, 8'h01, 3'b001});
        vecs.push_back('{16'h0412, 4'd4, 8'h00, 3'b110});
        vecs.push_back('{16'hF1A5, 4'd1, 8'hA5, 3'b110});
        vecs.push_back('{16'hF20F, 4'd2, 8'h0F, 3'b110});
        vecs.push_back('{16'h2512, 4'd5, 8'h05, 3'b000});
        vecs.push_back('{16'h3612, 4'd6, 8'hAF, 3'b001});
        vecs.push_back('{16'h4712, 4'd7, 8'hAA, 3'b001});
        vecs.push_back('{16'h5810, 4'd8, 8'h5A, 3'b000});
        vecs.push_back('{16'h6910, 4'd9, 8'h4A, 3'b010});
        vecs.push_back('{16'h7A10, 4'd10, 8'h52, 3'b010});
        vecs.push_back('{16'hF0FF, 4'd0, 8'h00, 3'b010});
        vecs.push_back('{16'h9123, 4'd1, 8'hA5, 3'b010});
        vecs.push_back('{16'h8010, 4'd0, 8'h00, 3'b001});
        vecs.push_back('{16'hF133, 4'd1, 8'h33, 3'b001});

        // Power-on reset, held across two edges with a writing instruction present.
        model_reset();
        #2 rst = 1'b1;
        inst = 16'hF1EE;
        #1;
        check("por x1", int'(dbg_data), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dbg_addr = 4'd1; #1;
        check("por hold x1", int'(dbg_data), 0);
        sweep("por");
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].inst);
            dbg_addr = vecs[k].addr;
            #1;
            check($sformatf("vec%0d data", k), int'(dbg_data), int'(vecs[k].data));
            check($sformatf("vec%0d flags", k), int'({flag_z, flag_c, flag_n}),
                  int'(vecs[k].znc));
            check($sformatf("vec%0d model", k), int'(dbg_data), m_rd(int'(vecs[k].addr)));
        end
        sweep("table");

        // Async reset between edges, with a write pending on inst.
        step(16'hF577);
        step(16'h1312);
        dbg_addr = 4'd5; #1;
        check("pre-rst x5", int'(dbg_data), 8'h77);
        check("pre-rst c", int'(flag_c), 1);
        inst = 16'hF5AA;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("async x5", int'(dbg_data), 0);
        check_flags("async");
        @(posedge clk); #1;
        check("rst held x5", int'(dbg_data), 0);
        @(negedge clk);
        rst = 1'b0;
        step(16'hF5AA);
        dbg_addr = 4'd5; #1;
        check("first write x5", int'(dbg_data), 8'hAA);
        sweep("post-rst");

        // Random instructions, LDI-weighted so registers carry varied data.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ri;
            logic [3:0]  rop;
            rop = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rop = 4'hF;
            ri = {rop, 12'($urandom)};
            step(ri);
            dbg_addr = ri[11:8];
            #1;
            check($sformatf("rnd%0d rd", n), int'(dbg_data), m_rd(int'(ri[11:8])));
            check_flags($sformatf("rnd%0d", n));
            if (n % 100 == 99) sweep($sformatf("rnd%0d sweep", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
